wb_la_bus_arbiter: RTL and testbench

- Shares one internal register-target port between two requesters: the management-core Wishbone slave interface and a firmware-driven Logic Analyzer (LA) command port.
- Sits inside TOP_digital, between the wrapper-level Wishbone/LA pins and the peripheral register bank.
- Round-robin arbitration; one transaction in flight at a time.
- A timeout terminates any access the target never acknowledges.

---
 rtl/wb_la_bus_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_wb_la_bus_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_la_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_la_bus_arbiter
//
// Shares one register-target port between two requesters:
//   * the management-core Wishbone slave (wbs_*), decoded against a window
//     whose upper address bits must equal BASE_ADDR[31:ADDR_W+2];
//   * a firmware-driven Logic Analyzer command port (la_*), where a rising
//     edge of la_req_i posts one request.
// Only one transaction is in flight at a time. Ties are settled round-robin
// against the last requester that was served. A target that never answers is
// cut off after TIMEOUT grant cycles, and the requester receives TIMEOUT_DATA.
//
// Ports
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   wbs_cyc/stb/we/sel/adr/dat_i Wishbone request (byte address)
//   wbs_ack_o, wbs_dat_o         one-cycle ack; read data, zero when not acking
//   la_req/we/adr/wdata_i        LA request (word address)
//   la_done_o, la_busy_o         one-cycle completion; pending-or-in-service
//   la_rdata_o                   last LA read result, held until next completion
//   t_req/we/sel/adr/wdata_o     target request and payload (registered)
//   t_ack_i, t_rdata_i           target single-cycle ack with read data
//   timeout_o                    one-cycle pulse when a grant timed out
//
// Handshake: t_req_o is a level "valid" that stays high, with t_we/sel/adr/
// wdata held constant, until the cycle the target raises t_ack_i (its "ready",
// which also qualifies t_rdata_i); the transfer completes on that edge and
// t_req_o drops on the next cycle. wbs_ack_o and la_done_o are the matching
// completions toward the requesters and are high for exactly one cycle.
// -----------------------------------------------------------------------------
module wb_la_bus_arbiter #(
  parameter int          ADDR_W       = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  // Wishbone slave
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  // Logic Analyzer command port
  input  logic              la_req_i,
  input  logic              la_we_i,
  input  logic [ADDR_W-1:0] la_adr_i,
  input  logic [31:0]       la_wdata_i,
  output logic              la_done_o,
  output logic              la_busy_o,
  output logic [31:0]       la_rdata_o,
  // Register target
  output logic              t_req_o,
  output logic              t_we_o,
  output logic [3:0]        t_sel_o,
  output logic [ADDR_W-1:0] t_adr_o,
  output logic [31:0]       t_wdata_o,
  input  logic              t_ack_i,
  input  logic [31:0]       t_rdata_i,
  output logic              timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GRANT_WB = 2'd1,
    S_GRANT_LA = 2'd2,
    S_RESP     = 2'd3
  } state_e;

  // Grant-cycle counter value on the last permitted grant cycle.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                owner_la_q, owner_la_d;   // owner of current/last grant
  logic                last_la_q, last_la_d;     // last requester served
  logic                la_req_q;                 // la_req_i delayed for edge detect
  logic                la_pend_q, la_pend_d;
  logic                t_req_q, t_req_d;
  logic                t_we_q, t_we_d;
  logic [3:0]          t_sel_q, t_sel_d;
  logic [ADDR_W-1:0]   t_adr_q, t_adr_d;
  logic [31:0]         t_wdata_q, t_wdata_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         la_rdata_q, la_rdata_d;
  logic                timeout_q, timeout_d;

  logic                wb_req;
  logic                la_edge;
  logic                grant_wb;
  logic                grant_la;
  logic [31:0]         cap_data;
  logic [1:0]          unused_adr;

  // Byte-lane bits of the Wishbone address do not take part in decoding.
  assign unused_adr = wbs_adr_i[1:0];

  assign wb_req  = wbs_cyc_i & wbs_stb_i &
                   (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign la_edge = la_req_i & ~la_req_q;

  // Tie-break: the requester that was not served last wins. Reset leaves
  // last_la_q set so Wishbone wins the first tie.
  assign grant_wb = wb_req & (~la_pend_q | last_la_q);
  assign grant_la = la_pend_q & (~wb_req | ~last_la_q);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= S_IDLE;
      owner_la_q <= 1'b0;
      last_la_q  <= 1'b1;
      la_req_q   <= 1'b0;
      la_pend_q  <= 1'b0;
      t_req_q    <= 1'b0;
      t_we_q     <= 1'b0;
      t_sel_q    <= 4'h0;
      t_adr_q    <= '0;
      t_wdata_q  <= 32'h0;
      cnt_q      <= 16'h0;
      rdata_q    <= 32'h0;
      la_rdata_q <= 32'h0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_la_q <= owner_la_d;
      last_la_q  <= last_la_d;
      la_req_q   <= la_req_i;
      la_pend_q  <= la_pend_d;
      t_req_q    <= t_req_d;
      t_we_q     <= t_we_d;
      t_sel_q    <= t_sel_d;
      t_adr_q    <= t_adr_d;
      t_wdata_q  <= t_wdata_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      la_rdata_q <= la_rdata_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_la_d = owner_la_q;
    last_la_d  = last_la_q;
    la_pend_d  = la_pend_q;
    t_req_d    = t_req_q;
    t_we_d     = t_we_q;
    t_sel_d    = t_sel_q;
    t_adr_d    = t_adr_q;
    t_wdata_d  = t_wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    la_rdata_d = la_rdata_q;
    timeout_d  = 1'b0;
    cap_data   = t_rdata_i;

    // A new LA edge only counts when nothing of the LA port is outstanding
    // or being served; otherwise it is dropped.
    if (la_edge && !la_pend_q && (state_q != S_GRANT_LA)) begin
      la_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (grant_wb) begin
          state_d    = S_GRANT_WB;
          owner_la_d = 1'b0;
          t_req_d    = 1'b1;
          t_we_d     = wbs_we_i;
          t_sel_d    = wbs_sel_i;
          t_adr_d    = wbs_adr_i[ADDR_W+1:2];
          t_wdata_d  = wbs_dat_i;
          cnt_d      = 16'h0;
        end else if (grant_la) begin
          state_d    = S_GRANT_LA;
          owner_la_d = 1'b1;
          la_pend_d  = 1'b0;
          t_req_d    = 1'b1;
          t_we_d     = la_we_i;
          t_sel_d    = 4'hF;
          t_adr_d    = la_adr_i;
          t_wdata_d  = la_wdata_i;
          cnt_d      = 16'h0;
        end
      end

      S_GRANT_WB,
      S_GRANT_LA: begin
        // An ack on the last permitted cycle beats the timeout.
        if (t_ack_i || (cnt_q == TO_LAST)) begin
          if (!t_ack_i) begin
            cap_data  = TIMEOUT_DATA;
            timeout_d = 1'b1;
          end
          rdata_d = cap_data;
          if (owner_la_q) begin
            la_rdata_d = cap_data;
          end
          t_req_d = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_RESP: begin
        last_la_d = owner_la_q;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        t_req_d = 1'b0;
      end
    endcase
  end

  assign wbs_ack_o  = (state_q == S_RESP) & ~owner_la_q;
  assign wbs_dat_o  = wbs_ack_o ? rdata_q : 32'h0;
  assign la_done_o  = (state_q == S_RESP) & owner_la_q;
  assign la_busy_o  = la_pend_q | (owner_la_q & (state_q != S_IDLE));
  assign la_rdata_o = la_rdata_q;
  assign t_req_o    = t_req_q;
  assign t_we_o     = t_we_q;
  assign t_sel_o    = t_sel_q;
  assign t_adr_o    = t_adr_q;
  assign t_wdata_o  = t_wdata_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_wb_la_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_la_bus_arbiter
//
// Bench for wb_la_bus_arbiter. A target model acknowledges t_req_o after a
// programmable number of grant cycles with data derived from the address.
// Expected target payloads and expected requester responses are queued when a
// request is driven and consumed when the DUT issues the grant / completion.
// -----------------------------------------------------------------------------
module tb_wb_la_bus_arbiter;

  localparam int          AW     = 8;
  localparam int          TO     = 255;
  localparam logic [31:0] TO_DAT = 32'hDEAD_BEEF;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- DUT
  logic          wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]    wbs_sel_i;
  logic [31:0]   wbs_adr_i, wbs_dat_i;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          la_req_i, la_we_i;
  logic [AW-1:0] la_adr_i;
  logic [31:0]   la_wdata_i;
  logic          la_done_o, la_busy_o;
  logic [31:0]   la_rdata_o;
  logic          t_req_o, t_we_o;
  logic [3:0]    t_sel_o;
  logic [AW-1:0] t_adr_o;
  logic [31:0]   t_wdata_o;
  logic          t_ack_i;
  logic [31:0]   t_rdata_i;
  logic          timeout_o;

  wb_la_bus_arbiter #(
    .ADDR_W(AW), .BASE_ADDR(32'h3000_0000), .TIMEOUT(TO), .TIMEOUT_DATA(TO_DAT)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .la_req_i(la_req_i), .la_we_i(la_we_i), .la_adr_i(la_adr_i),
    .la_wdata_i(la_wdata_i), .la_done_o(la_done_o), .la_busy_o(la_busy_o),
    .la_rdata_o(la_rdata_o),
    .t_req_o(t_req_o), .t_we_o(t_we_o), .t_sel_o(t_sel_o), .t_adr_o(t_adr_o),
    .t_wdata_o(t_wdata_o), .t_ack_i(t_ack_i), .t_rdata_i(t_rdata_i),
    .timeout_o(timeout_o)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [33:0] exp_q[$];    // {timeout, la_owner, data}
  logic [44:0] exp_t_q[$];  // {we, sel, adr, wdata}
  int          n_checks = 0;
  int          n_bad    = 0;
  int          n_grants = 0;
  int          tgt_wait = 0;          // grant cycles before ack; -1 = never
  logic [31:0] tgt_base = 32'h5A00_0000;
  logic        model_last_la = 1'b1;  // last requester served (reset: LA)

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] tgt_val(input logic [AW-1:0] adr);
    return tgt_base ^ {24'h0, adr};
  endfunction

  task automatic push_resp(input logic la, input logic [31:0] d, input logic tmo);
    exp_q.push_back({tmo, la, d});
    model_last_la = la;
  endtask

  // ---------------------------------------------------------------- target model
  initial begin : target
    int          gcyc;
    logic [44:0] cur_t;
    t_ack_i = 1'b0; t_rdata_i = 32'h0; gcyc = 0; cur_t = '0;
    forever begin
      @(negedge clk);
      t_ack_i = 1'b0; t_rdata_i = 32'h0;
      if (t_req_o) begin
        if (gcyc == 0) begin
          n_grants++;
          if (exp_t_q.size() == 0) check_eq("t_unexp", 64'(exp_t_q.size()), 64'd1);
          else begin
            cur_t = exp_t_q.pop_front();
            check_eq("t_payload", {t_we_o, t_sel_o, t_adr_o, t_wdata_o}, cur_t);
          end
        end else if (gcyc == tgt_wait) begin
          check_eq("t_payload_hold", {t_we_o, t_sel_o, t_adr_o, t_wdata_o}, cur_t);
        end
        if (gcyc == tgt_wait) begin
          t_ack_i = 1'b1; t_rdata_i = tgt_val(t_adr_o);
        end
        gcyc++;
      end else begin
        gcyc = 0;
      end
    end
  end

  // ---------------------------------------------------------------- response monitor
  initial begin : monitor
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (wbs_ack_o || la_done_o) begin
        if (exp_q.size() == 0) check_eq("resp_unexp", {wbs_ack_o, la_done_o}, 64'd0);
        else begin
          e = exp_q.pop_front();
          check_eq("resp", {timeout_o, la_done_o, la_done_o ? la_rdata_o : wbs_dat_o}, e);
        end
      end else begin
        check_eq("quiet", {timeout_o, wbs_dat_o}, 64'd0);
      end
    end
  end

  // Wishbone master releases stb on the edge that completes the ack.
  initial begin : wb_master
    forever begin
      @(negedge clk);
      if (wbs_ack_o) begin
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic wb_drive(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
  endtask

  task automatic wb_expect(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input logic tmo);
    exp_t_q.push_back({we, sel, adr[AW+1:2], dat});
    push_resp(1'b0, tmo ? TO_DAT : tgt_val(adr[AW+1:2]), tmo);
  endtask

  task automatic la_drive(input logic we, input logic [AW-1:0] adr,
                          input logic [31:0] wd);
    la_we_i = we; la_adr_i = adr; la_wdata_i = wd; la_req_i = 1'b1;
  endtask

  task automatic la_expect(input logic we, input logic [AW-1:0] adr,
                           input logic [31:0] wd);
    exp_t_q.push_back({we, 4'hF, adr, wd});
    push_resp(1'b1, tgt_val(adr), 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); n++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin : main
    int n;
    int g0;
    logic wb_first;
    rst_n = 1'b0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0;
    la_req_i = 0; la_we_i = 0; la_adr_i = 0; la_wdata_i = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_outs", {t_req_o, wbs_ack_o, la_done_o, la_busy_o, timeout_o, t_we_o, t_sel_o}, 64'd0);
    check_eq("rst_data", {la_rdata_o, t_wdata_o}, 64'd0);
    check_eq("rst_adr", t_adr_o, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1) WB write, zero-wait target, ack two cycles after stb
    tgt_wait = 0;
    wb_drive(1'b1, 32'h3000_0010, 32'h1234_5678, 4'hF);
    wb_expect(1'b1, 32'h3000_0010, 32'h1234_5678, 4'hF, 1'b0);
    n = 0;
    while (n < 20) begin
      @(negedge clk); n++;
      if (n == 1) begin
        check_eq("wr_t_adr", t_adr_o, 64'd4);
        check_eq("wr_t_wdata", t_wdata_o, 64'h1234_5678);
      end
      if (wbs_ack_o) break;
    end
    check_eq("wb_latency", n, 64'd2);
    @(negedge clk);
    check_eq("wb_ack_pulse", wbs_ack_o, 64'd0);
    wait_drain(50);

    // 2) LA read, target answers after 3 cycles
    tgt_wait = 3; tgt_base = 32'hCAFE_0000;
    check_eq("la_busy_pre", la_busy_o, 64'd0);
    la_drive(1'b0, 8'd7, 32'h0000_1111);
    la_expect(1'b0, 8'd7, 32'h0000_1111);
    n = 0;
    while (n < 50) begin
      @(negedge clk); n++;
      check_eq("la_busy_on", la_busy_o, 64'd1);
      if (la_done_o) break;
    end
    @(negedge clk);
    check_eq("la_done_pulse", la_done_o, 64'd0);
    check_eq("la_busy_off", la_busy_o, 64'd0);
    la_req_i = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("la_rdata_hold", la_rdata_o, 64'hCAFE_0007);
    wait_drain(50);

    // 3) four tie rounds, winner alternates against last served
    tgt_wait = 1; tgt_base = 32'h7700_0000;
    for (int r = 0; r < 4; r++) begin
      wb_first = model_last_la;
      la_drive(1'b1, 8'(8'h40 + r), 32'hA000_0000 + r);
      @(negedge clk);
      wb_drive(1'b0, 32'h3000_0100 + 32'(r * 4), 32'h0, 4'h3);
      if (wb_first) begin
        wb_expect(1'b0, 32'h3000_0100 + 32'(r * 4), 32'h0, 4'h3, 1'b0);
        la_expect(1'b1, 8'(8'h40 + r), 32'hA000_0000 + r);
      end else begin
        la_expect(1'b1, 8'(8'h40 + r), 32'hA000_0000 + r);
        wb_expect(1'b0, 32'h3000_0100 + 32'(r * 4), 32'h0, 4'h3, 1'b0);
      end
      wait_drain(100);
      la_req_i = 1'b0;
      @(negedge clk);
    end

    // 4) WB read, target never acks -> timeout after TO grant cycles
    tgt_wait = -1;
    wb_drive(1'b0, 32'h3000_0084, 32'h0, 4'hF);
    wb_expect(1'b0, 32'h3000_0084, 32'h0, 4'hF, 1'b1);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (wbs_ack_o) break;
      if (t_req_o) n++;
    end
    check_eq("tmo_cycles", n, 64'(TO));
    wait_drain(20);
    check_eq("tmo_idle", t_req_o, 64'd0);

    // ack on the final permitted cycle wins over the timeout
    tgt_wait = TO - 1; tgt_base = 32'h0BAD_F00D;
    wb_drive(1'b0, 32'h3000_0088, 32'h0, 4'hF);
    wb_expect(1'b0, 32'h3000_0088, 32'h0, 4'hF, 1'b0);
    wait_drain(400);

    // 5) out-of-window WB is ignored; held la_req_i gives one transaction
    tgt_wait = 0;
    wb_drive(1'b1, 32'h2000_0000, 32'h5555_5555, 4'hF);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (t_req_o) n++;
    end
    check_eq("oow_no_req", n, 64'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    g0 = n_grants;
    la_drive(1'b0, 8'h21, 32'h0);
    la_expect(1'b0, 8'h21, 32'h0);
    repeat (10) @(negedge clk);
    la_req_i = 1'b0;
    wait_drain(50);
    repeat (5) @(negedge clk);
    check_eq("la_level_once", n_grants - g0, 64'd1);

    // 6) reset during GRANT_LA
    tgt_wait = -1;
    la_drive(1'b1, 8'h33, 32'hFEED_0033);
    la_expect(1'b1, 8'h33, 32'hFEED_0033);
    n = 0;
    while (!t_req_o && n < 20) begin
      @(negedge clk); n++;
    end
    check_eq("rst_test_grant", t_req_o, 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_outs", {t_req_o, la_busy_o, la_done_o, wbs_ack_o, timeout_o, t_we_o, t_sel_o}, 64'd0);
    check_eq("arst_data", {la_rdata_o, t_wdata_o}, 64'd0);
    check_eq("arst_adr", {t_adr_o, wbs_dat_o}, 64'd0);
    exp_q.delete();
    exp_t_q.delete();
    model_last_la = 1'b1;
    la_req_i = 1'b0;
    tgt_wait = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wb_drive(1'b0, 32'h3000_03FC, 32'h0, 4'h1);
    wb_expect(1'b0, 32'h3000_03FC, 32'h0, 4'h1, 1'b0);
    wait_drain(50);
    repeat (5) @(negedge clk);
    check_eq("post_rst_busy", la_busy_o, 64'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_checks, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
